// File: rtl/mod_inv_verifier.sv
// rtl/mod_inv_verifier.sv - checks x is the inverse of a mod Q via bit-serial a*x mod Q
module mod_inv_verifier #(
    parameter int Q     = 7681,
    parameter int WIDTH = $clog2(Q),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product,
    output logic             out_pass,
    output logic             out_err,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0]  QW       = (WIDTH + 1)'(Q);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_r, x_r, acc;
    logic [BW-1:0]     bit_cnt;
    logic              err;
    logic [WIDTH:0]    dbl, dbl_red, sum, step;
    logic              range_bad, accept, deliver;

    // One interleaved step: acc*2 + x[bit]*a, each partial reduced once since both stay below 2Q
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= QW) ? dbl - QW : dbl;
        sum     = dbl_red + {1'b0, a_r};
        step    = dbl_red;
        if (x_r[bit_cnt]) begin
            step = (sum >= QW) ? sum - QW : sum;
        end
    end

    assign range_bad = ({1'b0, in_a} >= QW) || ({1'b0, in_x} >= QW);
    assign accept    = (state == IDLE) && in_valid;
    assign deliver   = (state == DONE) && out_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = range_bad ? DONE : MUL;
            MUL:     if (bit_cnt == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            a_r      <= '0;
            x_r      <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            err      <= 1'b0;
            fail_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_r     <= in_a;
                x_r     <= in_x;
                acc     <= '0;
                err     <= range_bad;
                bit_cnt <= LAST_BIT;
            end
            if (state == MUL) begin
                acc <= step[WIDTH-1:0];
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
            if (deliver && !out_pass && (fail_cnt != {CNT_W{1'b1}})) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    // Outputs decode straight from registers, so they hold while DONE waits on out_ready
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign out_product = acc;
    assign out_pass    = (state == DONE) && (acc == WIDTH'(1)) && !err;
    assign out_err     = (state == DONE) && err;
endmodule

// File: tb/tb_mod_inv_verifier.sv
// tb/tb_mod_inv_verifier.sv - directed table, corner sequences and soak for mod_inv_verifier
module tb_mod_inv_verifier;
    localparam int Q = 7681;
    localparam int W = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_product;
    logic          out_pass;
    logic          out_err;
    logic [15:0]   fail_cnt;

    int checks = 0;
    int errors = 0;
    int model_fail = 0;

    mod_inv_verifier #(.Q(Q), .WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_pass(out_pass), .out_err(out_err),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int x;
        int prod;
        int pass;
        int err;
        int lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents a pair, counts posedges from the accept edge (inclusive) until out_valid
    task automatic do_pair(input int a, input int x, output int lat, output logic timeout);
        timeout = 1'b1;
        lat = 0;
        @(negedge clk);
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        chk("in_ready_before_accept", int'(in_ready), 1);
        in_valid = 1'b1;
        in_a = W'(a);
        in_x = W'(x);
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (timeout) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic to;
        int a, x, p, d;
        vecs[0] = '{3,    5121, 1, 1, 0, 14};
        vecs[1] = '{3,    2561, 2, 0, 0, 14};
        vecs[2] = '{7680, 7680, 1, 1, 0, 14};
        vecs[3] = '{7681, 5,    0, 0, 1, 1};
        vecs[4] = '{0,    5,    0, 0, 0, 14};
        vecs[5] = '{5,    0,    0, 0, 0, 14};
        vecs[6] = '{8191, 8191, 0, 0, 1, 1};
        vecs[7] = '{2,    3841, 1, 1, 0, 14};
        vecs[8] = '{7680, 1,    7680, 0, 0, 14};

        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_product", int'(out_product), 0);
        chk("reset_pass", int'(out_pass), 0);
        chk("reset_err", int'(out_err), 0);
        chk("reset_fail_cnt", int'(fail_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_pair(vecs[i].a, vecs[i].x, lat, to);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_product", i), int'(out_product), vecs[i].prod);
            chk($sformatf("v%0d_pass", i), int'(out_pass), vecs[i].pass);
            chk($sformatf("v%0d_err", i), int'(out_err), vecs[i].err);
            chk($sformatf("v%0d_in_ready_low", i), int'(in_ready), 0);
            if (vecs[i].pass == 0) model_fail++;
            handshake();
            @(negedge clk);
            chk($sformatf("v%0d_in_ready_after", i), int'(in_ready), 1);
            chk($sformatf("v%0d_fail_cnt", i), int'(fail_cnt), model_fail);
        end

        // Backpressure: result held while out_ready low, stray in_valid ignored
        do_pair(1, 1, lat, to);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = W'(3);
            in_x = W'(2561);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_product", int'(out_product), 1);
            chk("bp_pass", int'(out_pass), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake();
        @(negedge clk);
        chk("bp_in_ready_after", int'(in_ready), 1);
        chk("bp_no_ghost", int'(out_valid), 0);
        chk("bp_fail_cnt", int'(fail_cnt), model_fail);

        // Reset mid-MUL abandons the operation and clears the counter
        @(negedge clk);
        in_valid = 1'b1;
        in_a = W'(3);
        in_x = W'(2561);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_product", int'(out_product), 0);
        @(negedge clk);
        reset = 1'b1;
        model_fail = 0;
        do_pair(2, 3841, lat, to);
        chk("post_rst_latency", lat, 14);
        chk("post_rst_product", int'(out_product), 1);
        chk("post_rst_pass", int'(out_pass), 1);
        handshake();

        // Soak with random operands and random output backpressure
        for (int n = 0; n < 1500; n++) begin
            a = int'($urandom_range(0, Q - 1));
            x = int'($urandom_range(0, Q - 1));
            p = (a * x) % Q;
            do_pair(a, x, lat, to);
            if (to) break;
            d = int'($urandom_range(0, 3));
            repeat (d) @(negedge clk);
            chk("soak_product", int'(out_product), p);
            chk("soak_pass", int'(out_pass), (p == 1) ? 1 : 0);
            chk("soak_err", int'(out_err), 0);
            if (p != 1) model_fail++;
            handshake();
            @(negedge clk);
            chk("soak_fail_cnt", int'(fail_cnt), model_fail);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
